// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_pkg
// Purpose  : Opcodes, FSM states and decoded control-word type for the sequencer
// Revision : 1.0
// ============================================================================
package control_sequencer_pkg;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    localparam logic [3:0] FS_PASSA_DEF = 4'h0;
    localparam logic [3:0] FS_PASSB_DEF = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_TGT  = 2'd1,
        PC_HOLD = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic [3:0] fs;
        logic       mb;
        logic       md;
        logic       mp;
        logic       rw;
        logic       dmem_req;
        logic       dmem_we;
        logic       illegal;
        logic       done;     // instruction completes on this edge
        logic       to_halt;
        pc_sel_t    pc_sel;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_sequencer_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_instr_decoder
// Purpose  : Combinational EXEC-state decode of opcode, memory ack and Z flag
// Revision : 1.0
// ============================================================================
module control_sequencer_instr_decoder
    import control_sequencer_pkg::*;
#(
    parameter logic [3:0] FS_PASSA = FS_PASSA_DEF,
    parameter logic [3:0] FS_PASSB = FS_PASSB_DEF
) (
    input  logic [3:0] i_op,
    input  logic       i_dmem_ack,
    input  logic       i_z,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl        = '0;
        o_ctrl.pc_sel = PC_INC;
        o_ctrl.done   = 1'b1;
        case (i_op)
            OP_LDI: begin
                o_ctrl.mb = 1'b1;
                o_ctrl.fs = FS_PASSB;
                o_ctrl.rw = 1'b1;
            end
            OP_LD: begin
                // Write back only once the load data is on DataIn
                o_ctrl.dmem_req = 1'b1;
                o_ctrl.md       = 1'b1;
                o_ctrl.rw       = i_dmem_ack;
                o_ctrl.done     = i_dmem_ack;
                o_ctrl.pc_sel   = i_dmem_ack ? PC_INC : PC_HOLD;
            end
            OP_ST: begin
                o_ctrl.dmem_req = 1'b1;
                o_ctrl.dmem_we  = 1'b1;
                o_ctrl.done     = i_dmem_ack;
                o_ctrl.pc_sel   = i_dmem_ack ? PC_INC : PC_HOLD;
            end
            OP_BZ: begin
                o_ctrl.fs     = FS_PASSA;
                o_ctrl.pc_sel = i_z ? PC_TGT : PC_INC;
            end
            OP_JMP: begin
                o_ctrl.pc_sel = PC_TGT;
            end
            OP_JAL: begin
                o_ctrl.mp     = 1'b1;
                o_ctrl.rw     = 1'b1;
                o_ctrl.pc_sel = PC_TGT;
            end
            OP_HALT: begin
                o_ctrl.pc_sel  = PC_HOLD;
                o_ctrl.to_halt = 1'b1;
            end
            OP_ILL: begin
                o_ctrl.illegal = 1'b1;
            end
            default: begin
                o_ctrl.fs = {1'b0, i_op[2:0]};
                o_ctrl.rw = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Multi-cycle fetch/execute control unit for the 16-bit datapath
// Revision : 1.0
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [3:0] FS_PASSA = FS_PASSA_DEF,
    parameter logic [3:0] FS_PASSB = FS_PASSB_DEF
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic [15:0] instr_in,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        Z,
    output logic [5:0]  PC,
    output logic [3:0]  DR,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  FS,
    output logic        MB,
    output logic        MD,
    output logic        RW,
    output logic        MP,
    output logic        halted,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       w_ctrl;

    control_sequencer_instr_decoder #(
        .FS_PASSA (FS_PASSA),
        .FS_PASSB (FS_PASSB)
    ) u_decoder (
        .i_op       (ir_q[15:12]),
        .i_dmem_ack (dmem_ack),
        .i_z        (Z),
        .o_ctrl     (w_ctrl)
    );

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= 6'd0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign PC = pc_q;
    assign DR = ir_q[11:8];
    assign SA = ir_q[7:4];
    assign SB = ir_q[3:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        FS       = 4'h0;
        MB       = 1'b0;
        MD       = 1'b0;
        RW       = 1'b0;
        MP       = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = instr_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                dmem_req = w_ctrl.dmem_req;
                dmem_we  = w_ctrl.dmem_we;
                FS       = w_ctrl.fs;
                MB       = w_ctrl.mb;
                MD       = w_ctrl.md;
                RW       = w_ctrl.rw;
                MP       = w_ctrl.mp;
                illegal  = w_ctrl.illegal;
                case (w_ctrl.pc_sel)
                    PC_INC:  pc_d = pc_q + 6'd1;   // 6-bit wrap is intended
                    PC_TGT:  pc_d = ir_q[5:0];
                    default: pc_d = pc_q;
                endcase
                if (w_ctrl.to_halt) begin
                    state_d = ST_HALT;
                end else if (w_ctrl.done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench: directed vector table plus randomized stream
// Revision : 1.0
// ============================================================================
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  idly;
        logic [3:0]  ddly;
        logic        z;
        logic [3:0]  fs;
        logic        mb, md, mp, rw, dreq, we, ill;
        logic [5:0]  npc;
    } vec_t;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] instr_in = 16'h0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        Z        = 1'b0;
    logic        imem_req, dmem_req, dmem_we, MB, MD, RW, MP, halted, illegal;
    logic [5:0]  PC;
    logic [3:0]  DR, SA, SB, FS;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] model_pc = 6'd0;
    vec_t       tbl [15];

    control_sequencer dut (
        .clk_main (clk_main), .reset (reset), .instr_in (instr_in),
        .imem_req (imem_req), .imem_ack (imem_ack),
        .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_ack (dmem_ack),
        .Z (Z), .PC (PC), .DR (DR), .SA (SA), .SB (SB), .FS (FS),
        .MB (MB), .MD (MD), .RW (RW), .MP (MP),
        .halted (halted), .illegal (illegal)
    );

    always #5 clk_main = ~clk_main;

    wire [30:0] all_out = {imem_req, dmem_req, dmem_we, halted, illegal,
                           MB, MD, RW, MP, FS, PC, DR, SA, SB};
    wire [12:0] ctrl_out = {FS, MB, MD, MP, RW, dmem_req, dmem_we, illegal,
                            imem_req, halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input int idly, input int ddly,
                                input logic z, input logic [3:0] fs, input logic mb,
                                input logic md, input logic mp, input logic rw,
                                input logic dreq, input logic we, input logic ill,
                                input logic [5:0] npc);
        vec_t v;
        v.instr = instr; v.idly = 4'(idly); v.ddly = 4'(ddly); v.z = z;
        v.fs = fs; v.mb = mb; v.md = md; v.mp = mp; v.rw = rw;
        v.dreq = dreq; v.we = we; v.ill = ill; v.npc = npc;
        return v;
    endfunction

    // Architectural model: what the instruction does, read straight from the ISA rules
    function automatic vec_t model(input logic [15:0] instr, input logic z,
                                   input logic [5:0] pc, input int idly, input int ddly);
        int   op;
        int   npc;
        vec_t v;
        op = int'(instr[15:12]);
        v  = mk(instr, idly, ddly, z, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        if (op < 8)  v.fs = 4'(op);
        if (op == 8) v.fs = 4'hC;
        v.mb   = (op == 8);
        v.md   = (op == 9);
        v.mp   = (op == 13);
        v.rw   = (op <= 9) || (op == 13);
        v.dreq = (op == 9) || (op == 10);
        v.we   = (op == 10);
        v.ill  = (op == 15);
        npc    = (int'(pc) + 1) % 64;
        if ((op == 11 && z) || op == 12 || op == 13) npc = int'(instr[5:0]);
        if (op == 14) npc = int'(pc);
        v.npc  = 6'(npc);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk_main);
        reset = 1'b0;
        #1 check("reset_outs", 32'(all_out), 32'h0);
        repeat (3) @(negedge clk_main);
        reset = 1'b1;
        #1 check("idle_outs", 32'(all_out), 32'h0);
        model_pc = 6'd0;
    endtask

    task automatic run_vec(input vec_t v, input bit spurious);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            @(negedge clk_main); #1;
            k++;
        end
        if (imem_req !== 1'b1) begin
            check("fetch_timeout", 32'(imem_req), 32'h1);
            return;
        end
        check("fetch_pc", 32'(PC), 32'(model_pc));
        check("fetch_rw", 32'(RW), 32'h0);
        for (int i = 0; i < int'(v.idly); i++) begin
            imem_ack = 1'b0;
            dmem_ack = spurious ? 1'($urandom) : 1'b0;
            #1 check("imem_req_hold", 32'(imem_req), 32'h1);
            @(negedge clk_main); #1;
        end
        imem_ack = 1'b1;
        instr_in = v.instr;
        dmem_ack = 1'b0;
        @(negedge clk_main); #1;
        imem_ack = spurious ? 1'($urandom) : 1'b0;
        instr_in = 16'($urandom);
        Z        = v.z;
        if (v.dreq) begin
            for (int i = 0; i < int'(v.ddly); i++) begin
                dmem_ack = 1'b0;
                #1;
                check("dmem_wait", 32'({dmem_req, dmem_we, RW}), 32'({1'b1, v.we, 1'b0}));
                @(negedge clk_main); #1;
            end
            dmem_ack = 1'b1;
        end else begin
            dmem_ack = spurious ? 1'($urandom) : 1'b0;
        end
        #1;
        check("exec_ctrl", 32'(ctrl_out),
              32'({v.fs, v.mb, v.md, v.mp, v.rw, v.dreq, v.we, v.ill, 2'b00}));
        check("exec_fields", 32'({DR, SA, SB}), 32'(v.instr[11:0]));
        @(negedge clk_main); #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        model_pc = v.npc;
        if (v.instr[15:12] != 4'hE) begin
            check("rw_single", 32'(RW), 32'h0);
            check("refetch", 32'(imem_req), 32'h1);
        end else begin
            check("halt_entry", 32'(halted), 32'h1);
        end
    endtask

    initial begin
        tbl[0]  = mk(16'h8312, 2, 0, 1'b0, 4'hC, 1,0,0,1, 0,0,0, 6'd1);
        tbl[1]  = mk(16'h9250, 0, 3, 1'b0, 4'h0, 0,1,0,1, 1,0,0, 6'd2);
        tbl[2]  = mk(16'hA045, 1, 2, 1'b0, 4'h0, 0,0,0,0, 1,1,0, 6'd3);
        tbl[3]  = mk(16'h0123, 0, 0, 1'b0, 4'h0, 0,0,0,1, 0,0,0, 6'd4);
        tbl[4]  = mk(16'h7456, 1, 0, 1'b0, 4'h7, 0,0,0,1, 0,0,0, 6'd5);
        tbl[5]  = mk(16'hB02A, 0, 0, 1'b1, 4'h0, 0,0,0,0, 0,0,0, 6'd42);
        tbl[6]  = mk(16'hC005, 0, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,0, 6'd5);
        tbl[7]  = mk(16'hB02A, 0, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,0, 6'd6);
        tbl[8]  = mk(16'h3ABC, 3, 0, 1'b1, 4'h3, 0,0,0,1, 0,0,0, 6'd7);
        tbl[9]  = mk(16'hC03F, 0, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,0, 6'd63);
        tbl[10] = mk(16'hD710, 0, 0, 1'b0, 4'h0, 0,0,1,1, 0,0,0, 6'd16);
        tbl[11] = mk(16'hC03F, 0, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,0, 6'd63);
        tbl[12] = mk(16'h5000, 0, 0, 1'b0, 4'h5, 0,0,0,1, 0,0,0, 6'd0);
        tbl[13] = mk(16'hF000, 0, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,1, 6'd1);
        tbl[14] = mk(16'hE000, 1, 0, 1'b0, 4'h0, 0,0,0,0, 0,0,0, 6'd1);

        do_reset();
        @(negedge clk_main); #1;
        check("fetch_first", 32'(all_out), 32'({1'b1, 30'b0}));
        reset = 1'b0;
        #1 check("async_drop", 32'(imem_req), 32'h0);
        @(negedge clk_main);
        reset = 1'b1;
        #1 model_pc = 6'd0;

        for (int i = 0; i < 15; i++) run_vec(tbl[i], 1'b0);

        for (int i = 0; i < 12; i++) begin
            imem_ack = 1'($urandom);
            @(negedge clk_main); #1;
            check("halt_hold", 32'({halted, imem_req, RW, PC}), 32'({1'b1, 1'b0, 1'b0, 6'd1}));
        end
        imem_ack = 1'b0;
        do_reset();

        for (int i = 0; i < 80; i++) begin
            logic [15:0] ins;
            int          op;
            op  = $urandom_range(0, 14);
            if (op == 14) op = 15;
            ins = 16'($urandom);
            ins[15:12] = 4'(op);
            run_vec(model(ins, 1'($urandom), model_pc, $urandom_range(0, 3),
                          $urandom_range(0, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
